// File: rtl/jinv_bist.sv
// Built-in self test for a single inverter: drives 1,0,1,0... and checks y_obs == ~a_drv.
// Latency: VECTORS*(SETTLE+2) cycles from the start-sampling edge to done.
// Backpressure: none; start is ignored while a run is in progress.
module jinv_bist #(
   parameter int SETTLE  = 4,
   parameter int VECTORS = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   output logic       a_drv,
   input  logic       y_obs,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [3:0] fail_cnt,
   output logic [3:0] vec_idx
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      DRIVE  = 3'd1,
      SETTLE_ST = 3'd2,
      CHECK  = 3'd3,
      DONE   = 3'd4
   } state_t;

   localparam logic [3:0] LAST_IDX    = 4'(VECTORS - 1);
   localparam logic [7:0] SETTLE_LAST = 8'(SETTLE - 1);

   state_t     state_q, state_d;
   logic       a_drv_q, a_drv_d;
   logic [3:0] fail_cnt_q, fail_cnt_d;
   logic [3:0] vec_idx_q, vec_idx_d;
   logic [7:0] settle_cnt_q, settle_cnt_d;
   logic [3:0] vec_idx_inc;

   // State and datapath registers; reset clears everything asynchronously.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         a_drv_q      <= 1'b0;
         fail_cnt_q   <= 4'd0;
         vec_idx_q    <= 4'd0;
         settle_cnt_q <= 8'd0;
      end else begin
         state_q      <= state_d;
         a_drv_q      <= a_drv_d;
         fail_cnt_q   <= fail_cnt_d;
         vec_idx_q    <= vec_idx_d;
         settle_cnt_q <= settle_cnt_d;
      end
   end

   // Next-state, stimulus, settle timing and mismatch counting.
   always_comb begin
      state_d      = state_q;
      a_drv_d      = a_drv_q;
      fail_cnt_d   = fail_cnt_q;
      vec_idx_d    = vec_idx_q;
      settle_cnt_d = settle_cnt_q;
      vec_idx_inc  = vec_idx_q + 4'd1;
      case (state_q)
         IDLE, DONE: begin
            a_drv_d = 1'b0;
            if (start) begin
               state_d      = DRIVE;
               fail_cnt_d   = 4'd0;
               vec_idx_d    = 4'd0;
               settle_cnt_d = 8'd0;
               // vector 0 is even, so it drives a 1
               a_drv_d      = 1'b1;
            end
         end
         DRIVE: begin
            state_d      = SETTLE_ST;
            settle_cnt_d = 8'd0;
         end
         SETTLE_ST: begin
            if (settle_cnt_q == SETTLE_LAST) begin
               state_d = CHECK;
            end else begin
               settle_cnt_d = settle_cnt_q + 8'd1;
            end
         end
         CHECK: begin
            // counter saturates at 15 rather than wrapping
            if ((y_obs != ~a_drv_q) && (fail_cnt_q != 4'hF)) begin
               fail_cnt_d = fail_cnt_q + 4'd1;
            end
            if (vec_idx_q == LAST_IDX) begin
               state_d = DONE;
               a_drv_d = 1'b0;
            end else begin
               state_d   = DRIVE;
               vec_idx_d = vec_idx_inc;
               a_drv_d   = ~vec_idx_inc[0];
            end
         end
         default: begin
            state_d = IDLE;
            a_drv_d = 1'b0;
         end
      endcase
   end

   // Status outputs decoded from the registered state.
   always_comb begin
      busy     = (state_q == DRIVE) || (state_q == SETTLE_ST) || (state_q == CHECK);
      done     = (state_q == DONE);
      pass     = (state_q == DONE) && (fail_cnt_q == 4'd0);
      a_drv    = a_drv_q;
      fail_cnt = fail_cnt_q;
      vec_idx  = vec_idx_q;
   end

endmodule

// File: tb/tb_jinv_bist.sv
// Self-checking bench for jinv_bist: table of inverter-model runs plus
// hand-written sequences for restart-from-DONE and mid-run reset.
module tb_jinv_bist;

   logic       clk = 1'b0;
   logic       reset;
   logic       start0, start1;
   logic       a0, a1, y0, y1;
   logic       busy0, busy1, done0, done1, pass0, pass1;
   logic [3:0] fc0, fc1, vi0, vi1;
   int         mode;   // 0 inverter, 1 stuck-0, 2 stuck-1, 3 buffer
   int         sel;

   logic       cur_busy, cur_done, cur_pass, cur_a;
   logic [3:0] cur_fc, cur_vi;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   jinv_bist dut0 (
      .clk(clk), .reset(reset), .start(start0), .a_drv(a0), .y_obs(y0),
      .busy(busy0), .done(done0), .pass(pass0), .fail_cnt(fc0), .vec_idx(vi0)
   );

   jinv_bist #(.SETTLE(1), .VECTORS(16)) dut1 (
      .clk(clk), .reset(reset), .start(start1), .a_drv(a1), .y_obs(y1),
      .busy(busy1), .done(done1), .pass(pass1), .fail_cnt(fc1), .vec_idx(vi1)
   );

   function automatic logic model(input int m, input logic a);
      case (m)
         0: return ~a;
         1: return 1'b0;
         2: return 1'b1;
         default: return a;
      endcase
   endfunction

   always_comb begin
      y0 = model(mode, a0);
      y1 = model(mode, a1);
      cur_busy = (sel == 1) ? busy1 : busy0;
      cur_done = (sel == 1) ? done1 : done0;
      cur_pass = (sel == 1) ? pass1 : pass0;
      cur_a    = (sel == 1) ? a1 : a0;
      cur_fc   = (sel == 1) ? fc1 : fc0;
      cur_vi   = (sel == 1) ? vi1 : vi0;
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic set_start(input logic v);
      start0 = (sel == 0) ? v : 1'b0;
      start1 = (sel == 1) ? v : 1'b0;
   endtask

   // Runs one BIST pass; n = edges from start-sampling edge to done.
   task automatic run(input int per, input bit hold, input int pulse_at,
                      output int n, output int seq_err);
      int exp_idx;
      logic [3:0] idx4;
      n = 0;
      seq_err = 0;
      set_start(1'b1);
      @(posedge clk); #1;
      if (!hold) set_start(1'b0);
      while (!cur_done && n < 200) begin
         exp_idx = n / per;
         idx4 = 4'(exp_idx);
         if (cur_busy !== 1'b1 || cur_a !== ~idx4[0] || cur_vi !== idx4) seq_err++;
         if (n == pulse_at) set_start(1'b1);
         else if (!hold) set_start(1'b0);
         @(posedge clk); #1;
         n++;
      end
      set_start(1'b0);
   endtask

   typedef struct {
      int sel;
      int mode;
      bit hold;
      int pulse_at;
      int exp_cycles;
      int exp_fail;
      int exp_pass;
      int exp_idx;
   } vec_t;

   vec_t tbl[8];

   initial begin
      int n, se;
      tbl[0] = '{0, 0, 0, -1, 24, 0, 1, 3};
      tbl[1] = '{0, 1, 0, -1, 24, 2, 0, 3};
      tbl[2] = '{0, 2, 0, -1, 24, 2, 0, 3};
      tbl[3] = '{0, 3, 0, -1, 24, 4, 0, 3};
      tbl[4] = '{1, 3, 0, -1, 48, 15, 0, 15};
      tbl[5] = '{1, 0, 0, -1, 48, 0, 1, 15};
      tbl[6] = '{0, 0, 1, -1, 24, 0, 1, 3};
      tbl[7] = '{0, 1, 0, 10, 24, 2, 0, 3};

      sel = 0;
      mode = 0;
      start0 = 1'b0;
      start1 = 1'b0;
      reset = 1'b1;
      #2;
      chk("rst_busy", int'(busy0), 0);
      chk("rst_done", int'(done0), 0);
      chk("rst_pass", int'(pass0), 0);
      chk("rst_adrv", int'(a0), 0);
      chk("rst_fail", int'(fc0), 0);
      chk("rst_idx", int'(vi0), 0);
      chk("rst_busy16", int'(busy1), 0);

      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("idle_busy", int'(busy0), 0);
      chk("idle_done", int'(done0), 0);
      chk("idle_adrv", int'(a0), 0);

      for (int i = 0; i < 8; i++) begin
         sel = tbl[i].sel;
         mode = tbl[i].mode;
         run((tbl[i].sel == 1) ? 3 : 6, tbl[i].hold, tbl[i].pulse_at, n, se);
         chk($sformatf("v%0d_cycles", i), n, tbl[i].exp_cycles);
         chk($sformatf("v%0d_seq", i), se, 0);
         chk($sformatf("v%0d_done", i), int'(cur_done), 1);
         chk($sformatf("v%0d_busy", i), int'(cur_busy), 0);
         chk($sformatf("v%0d_adrv", i), int'(cur_a), 0);
         chk($sformatf("v%0d_fail", i), int'(cur_fc), tbl[i].exp_fail);
         chk($sformatf("v%0d_pass", i), int'(cur_pass), tbl[i].exp_pass);
         chk($sformatf("v%0d_idx", i), int'(cur_vi), tbl[i].exp_idx);
      end

      // DONE holds its result, then a start there clears and reruns.
      sel = 0;
      repeat (3) @(posedge clk);
      #1;
      chk("hold_done", int'(done0), 1);
      chk("hold_fail", int'(fc0), 2);
      chk("hold_idx", int'(vi0), 3);
      mode = 0;
      start0 = 1'b1;
      @(posedge clk); #1;
      start0 = 1'b0;
      chk("rerun_busy", int'(busy0), 1);
      chk("rerun_done", int'(done0), 0);
      chk("rerun_fail", int'(fc0), 0);
      chk("rerun_idx", int'(vi0), 0);
      chk("rerun_adrv", int'(a0), 1);
      n = 0;
      while (!done0 && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      chk("rerun_cycles", n, 24);
      chk("rerun_pass", int'(pass0), 1);

      // Reset between edges during SETTLE of vector 2 with a faulty model.
      mode = 1;
      start0 = 1'b1;
      @(posedge clk); #1;
      start0 = 1'b0;
      repeat (13) @(posedge clk);
      #1;
      chk("pre_rst_idx", int'(vi0), 2);
      chk("pre_rst_fail", int'(fc0), 1);
      chk("pre_rst_adrv", int'(a0), 1);
      #3;
      reset = 1'b1;
      #1;
      chk("mid_rst_busy", int'(busy0), 0);
      chk("mid_rst_done", int'(done0), 0);
      chk("mid_rst_pass", int'(pass0), 0);
      chk("mid_rst_adrv", int'(a0), 0);
      chk("mid_rst_fail", int'(fc0), 0);
      chk("mid_rst_idx", int'(vi0), 0);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk); #1;
      chk("post_rst_idle", int'(busy0), 0);
      mode = 0;
      run(6, 1'b0, -1, n, se);
      chk("post_rst_cycles", n, 24);
      chk("post_rst_seq", se, 0);
      chk("post_rst_pass", int'(pass0), 1);
      chk("post_rst_fail", int'(fc0), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
